// File: rtl/vj_face_collector.sv
// ---------------------------------------------------------------------------
// vj_face_collector
//
// Collects Viola-Jones detections (window index + pyramid level), converts
// them to original-image coordinates and window size using a Q8.8 scale
// table, buffers them in a FIFO and streams them to a downstream reader.
// End-of-frame markers are inserted on request. Detections that cannot be
// stored are counted as drops.
//
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   top_left            [0] = x (column), [1] = y (row) window index
//   pyramid_number      pyramid level of the detection
//   top_left_ready      detection valid this cycle (no backpressure)
//   frame_start         pulse: flush pipeline, FIFO, marker and counters
//   frame_end           pulse: request an end-of-frame marker
//   out_valid/out_ready valid/ready handshake of the output stream
//   out_x/out_y/out_size scaled coordinates and window edge (size 0 = marker)
//   out_last            head entry is an end-of-frame marker
//   face_count          detections stored this frame (saturating)
//   drop_count          detections discarded this frame (saturating)
//   busy                pipeline, pending marker or FIFO hold data
// ---------------------------------------------------------------------------
module vj_face_collector #(
  parameter int          DEPTH    = 32,
  parameter int          WIN      = 24,
  parameter int          NUM_PYR  = 10,
  parameter logic [15:0] SCALE_Q8 [0:NUM_PYR-1] = '{16'd256, 16'd320, 16'd400,
    16'd500, 16'd625, 16'd781, 16'd977, 16'd1221, 16'd1526, 16'd1907}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0][31:0] top_left,
  input  logic [3:0]       pyramid_number,
  input  logic             top_left_ready,
  input  logic             frame_start,
  input  logic             frame_end,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_x,
  output logic [15:0]      out_y,
  output logic [15:0]      out_size,
  output logic             out_last,
  output logic [15:0]      face_count,
  output logic [15:0]      drop_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  // val * scale in Q8.8, rounded to nearest, saturated to 16 bits.
  function automatic logic [15:0] scale_sat(input logic [31:0] val,
                                            input logic [15:0] scale);
    logic [47:0] prod;
    logic [47:0] rnd;
    prod = {16'd0, val} * {32'd0, scale};
    rnd  = prod + 48'd128;
    if (rnd[47:24] != 24'd0) begin
      return 16'hFFFF;
    end else begin
      return rnd[23:8];
    end
  endfunction

  // Saturating add of up to two single-cycle events.
  function automatic logic [15:0] sat_add2(input logic [15:0] cnt,
                                           input logic a,
                                           input logic b);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {16'd0, a} + {16'd0, b};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

  // Stage 1 registers
  logic [31:0] x1;
  logic [31:0] y1;
  logic [3:0]  lvl1;
  logic        v1;

  // Stage 2 registers (scaled results)
  logic [15:0] x2;
  logic [15:0] y2;
  logic [15:0] size2;
  logic        v2;

  // FIFO storage and pointers (extra MSB separates full from empty)
  logic [15:0] mem_x    [DEPTH];
  logic [15:0] mem_y    [DEPTH];
  logic [15:0] mem_size [DEPTH];
  logic        mem_last [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        mark_pend;

  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        space;
  logic        s2_bad;
  logic        s3_write;
  logic        s3_drop;
  logic        mark_write;
  logic        wr_en;
  logic [15:0] scale_sel;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign space      = ~fifo_full | pop;

  assign s2_bad     = v1 && (int'(lvl1) >= NUM_PYR);
  assign s3_write   = v2 & space;
  assign s3_drop    = v2 & ~space;
  // The marker waits until every detection ahead of it has been written,
  // so it always lands after the frame's last detection.
  assign mark_write = mark_pend & ~v1 & ~v2 & space;
  assign wr_en      = s3_write | mark_write;

  // Scale-table lookup; out-of-range levels select 0 and are dropped anyway.
  always_comb begin
    scale_sel = 16'd0;
    for (int i = 0; i < NUM_PYR; i++) begin
      scale_sel = (lvl1 == 4'(i)) ? SCALE_Q8[i] : scale_sel;
    end
  end

  // S1: capture every detection pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      x1   <= 32'd0;
      y1   <= 32'd0;
      lvl1 <= 4'd0;
    end else if (frame_start) begin
      v1 <= 1'b0;
    end else begin
      v1 <= top_left_ready;
      if (top_left_ready) begin
        x1   <= top_left[0];
        y1   <= top_left[1];
        lvl1 <= pyramid_number;
      end
    end
  end

  // S2: scale coordinates and window edge; invalid levels are discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2    <= 1'b0;
      x2    <= 16'd0;
      y2    <= 16'd0;
      size2 <= 16'd0;
    end else if (frame_start) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1 & ~s2_bad;
      if (v1 && !s2_bad) begin
        x2    <= scale_sat(x1, scale_sel);
        y2    <= scale_sat(y1, scale_sel);
        size2 <= scale_sat(32'(WIN), scale_sel);
      end
    end
  end

  // FIFO storage write (detection or marker); contents need no reset
  // because the outputs are gated by out_valid.
  always_ff @(posedge clock) begin
    if (wr_en && !frame_start) begin
      mem_x[wr_ptr[AW-1:0]]    <= s3_write ? x2    : 16'd0;
      mem_y[wr_ptr[AW-1:0]]    <= s3_write ? y2    : 16'd0;
      mem_size[wr_ptr[AW-1:0]] <= s3_write ? size2 : 16'd0;
      mem_last[wr_ptr[AW-1:0]] <= ~s3_write;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Pending end-of-frame marker; a second request while pending is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mark_pend <= 1'b0;
    end else if (frame_start) begin
      mark_pend <= 1'b0;
    end else if (mark_write) begin
      mark_pend <= 1'b0;
    end else if (frame_end) begin
      mark_pend <= 1'b1;
    end
  end

  // Per-frame counters; S2 and S3 drops may coincide and add 2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      face_count <= 16'd0;
      drop_count <= 16'd0;
    end else if (frame_start) begin
      face_count <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      face_count <= sat_add2(face_count, s3_write, 1'b0);
      drop_count <= sat_add2(drop_count, s2_bad, s3_drop);
    end
  end

  assign out_x    = out_valid ? mem_x[rd_ptr[AW-1:0]]    : 16'd0;
  assign out_y    = out_valid ? mem_y[rd_ptr[AW-1:0]]    : 16'd0;
  assign out_size = out_valid ? mem_size[rd_ptr[AW-1:0]] : 16'd0;
  assign out_last = out_valid ? mem_last[rd_ptr[AW-1:0]] : 1'b0;
  assign busy     = v1 | v2 | mark_pend | ~fifo_empty;

endmodule

// File: doc/vj_face_collector.md
# vj_face_collector

Receive-side counterpart of the Viola-Jones pipeline's detection output. Accepts every `top_left_ready` pulse (window index plus pyramid level) and converts pyramid-level coordinates to original-image coordinates and window size using a fixed-point scale table. Buffers results in a FIFO and drains them to a downstream reader over a valid/ready stream, with frame markers, drop accounting and saturation.

## Interface

Parameters:
- `DEPTH`, 32: FIFO entries; power of two, at least 4.
- `WIN`, 24: detection window edge, in pyramid pixels.
- `NUM_PYR`, 10: number of valid pyramid levels.
- `SCALE_Q8`, {256,320,400,500,625,781,977,1221,1526,1907}: per-level scale factor, unsigned Q8.8, 16 bits each. Index = pyramid level.

Ports:
- `clock` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `top_left` in [1:0][31:0]: detection window index; [0] = x (column), [1] = y (row), unsigned.
- `pyramid_number` in 4: pyramid level of the detection.
- `top_left_ready` in 1: detection valid this cycle; may be high on consecutive cycles.
- `frame_start` in 1: pulse; flushes FIFO, in-flight stages and counters.
- `frame_end` in 1: pulse; requests an end-of-frame marker.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accept.
- `out_x` out 16: scaled x.
- `out_y` out 16: scaled y.
- `out_size` out 16: scaled window edge; 0 for a marker.
- `out_last` out 1: entry is an end-of-frame marker.
- `face_count` out 16: detections written to FIFO this frame; saturates at 0xFFFF.
- `drop_count` out 16: detections discarded this frame; saturates at 0xFFFF.
- `busy` out 1: any stage holds data, marker pending, or FIFO non-empty.

## Operation

- S1 capture: on `top_left_ready`, register x, y and level, and set v1. No backpressure toward the pipeline; every pulse is captured.
- S2 scale: if level >= `NUM_PYR`, clear v2 and increment `drop_count`. Otherwise compute each of x, y and `WIN` as val*scale (48-bit product), add 128, shift right by 8. If the result exceeds 0xFFFF, output 0xFFFF. Register the results and v2.
- S3 write: if v2 and the FIFO has space, write an entry with last=0 and increment `face_count`; else drop and increment `drop_count`.
- Space rule: a write is permitted when the FIFO is not full, or when it is full and a read (`out_valid & out_ready`) happens in the same cycle.
- Marker: `frame_end` sets `mark_pend`. The marker {0,0,0,last=1} is written once S1/S2/S3 hold no valid data, no S3 detection write occurs that cycle, and the FIFO has space. Then clear `mark_pend`.
- A marker is never dropped. `frame_end` while `mark_pend` is already set is ignored.
- Output: `out_x`/`out_y`/`out_size`/`out_last` reflect the FIFO head, registered storage. They hold stable while `out_valid & ~out_ready`. A pop happens on `out_valid & out_ready`.
- `frame_start` is synchronous and takes priority over everything else that cycle. It clears v1, v2, FIFO pointers, `mark_pend` and both counters. A `top_left_ready` in the same cycle is discarded and not counted.
- Counters increment by at most 1 per cause per cycle. When an S2 invalid-level drop and an S3 full drop coincide, `drop_count` increments by 2, then saturates.

## Timing

- Reset values: `out_valid`=0, `out_x`=`out_y`=`out_size`=0, `out_last`=0, `face_count`=`drop_count`=0, `busy`=0. FIFO empty, v1=v2=0, `mark_pend`=0.
- Latency: `top_left_ready` in cycle 0 with an empty FIFO gives `out_valid`=1 in cycle 3 with the entry data.
- Throughput: one detection per cycle in, one entry per cycle out.
- Marker: `frame_end` in cycle 0 with an idle pipeline and non-full FIFO gives the marker written at the cycle 1 edge. `out_valid` appears in cycle 2 if the FIFO was empty.
- FIFO pointers wrap modulo `DEPTH`. Full/empty are distinguished by an extra pointer bit.
- Reset mid-operation discards all data immediately (asynchronous).

## Test plan

- Level 0, x=10, y=20, `out_ready`=1 -> cycle 3: `out_valid`=1, (10,20,24), last=0, `face_count`=1.
- Level 2, x=10, y=20 -> (16,31,38). Level 12 -> no entry, `drop_count`=1.
- `out_ready`=0, 34 back-to-back detections at level 0 -> 32 entries stored, `drop_count`=2. Then `out_ready`=1 -> 32 entries drained in order, with the x sequence matching the input.
- Full FIFO with `out_ready`=1 and a simultaneous new detection -> written, nothing dropped, count stays 32.
- Detection then `frame_end` one cycle later -> detection entry, then marker (0,0,0,last=1). `busy` falls after the marker pops.
- x=0xFFFFFFFF at level 9 -> `out_x`=0xFFFF. `frame_start` mid-burst -> FIFO empty, counters 0 next cycle. Asynchronous reset mid-drain -> all outputs 0 immediately.
